// File: rtl/mux_scan_ctrl_if.sv
// Control/status bundle between the scan controller and its host.
// Host drives scan requests; controller returns the select lines and the aligned sample tags.
interface mux_scan_ctrl_if #(
  parameter int DWELL_W = 4
);
  logic               start;
  logic               stop;
  logic               mode;
  logic [3:0]         ch_mask;
  logic [DWELL_W-1:0] dwell;
  logic               s0;
  logic               s1;
  logic               busy;
  logic               sample_vld;
  logic [1:0]         sample_ch;
  logic               done;

  modport master (
    output start, stop, mode, ch_mask, dwell,
    input  s0, s1, busy, sample_vld, sample_ch, done
  );

  modport slave (
    input  start, stop, mode, ch_mask, dwell,
    output s0, s1, busy, sample_vld, sample_ch, done
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scan controller for the pipelined 4:1 mux: steps the selects over the enabled channels
// and emits a channel tag/valid delayed by the mux latency so capture needs no bookkeeping.
module mux_scan_ctrl #(
  parameter int DWELL_W = 4,
  parameter int LAT     = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  mux_scan_ctrl_if.slave  bus
);

  localparam int DRN_W = $clog2(LAT + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_e;

  state_e               state_q, state_d;
  logic [3:0]           mask_q, mask_d;
  logic                 mode_q, mode_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [1:0]           ch_q, ch_d;
  logic                 stop_q, stop_d;
  logic [DRN_W-1:0]     drn_q, drn_d;
  logic                 done_q, done_d;
  logic                 tag_vld;
  logic [DWELL_W-1:0]   dwell_last;
  logic                 last_dwell;
  logic [LAT-1:0][2:0]  dly_q;

  // Next enabled channel in ascending order with wrap; returns c itself if it is the only one.
  function automatic logic [1:0] next_ch(input logic [3:0] m, input logic [1:0] c);
    logic [1:0] r;
    logic [1:0] k;
    r = c;
    for (int i = 3; i >= 1; i--) begin
      k = c + 2'(i);
      if (m[k]) r = k;
    end
    return r;
  endfunction

  function automatic logic is_top(input logic [3:0] m, input logic [1:0] c);
    logic top;
    top = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > int'(c) && m[i]) top = 1'b0;
    end
    return top;
  endfunction

  assign dwell_last = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);
  assign last_dwell = (cnt_q == dwell_last);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    mode_d  = mode_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    stop_d  = stop_q;
    drn_d   = drn_q;
    done_d  = 1'b0;
    tag_vld = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.ch_mask != 4'b0000) begin
            mask_d  = bus.ch_mask;
            mode_d  = bus.mode;
            dwell_d = bus.dwell;
            ch_d    = next_ch(bus.ch_mask, 2'd3);
            cnt_d   = '0;
            stop_d  = 1'b0;
            state_d = SCAN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SCAN: begin
        stop_d = stop_q | bus.stop;
        if (last_dwell) begin
          tag_vld = 1'b1;
          cnt_d   = '0;
          // Abort or end of a single sweep leaves the select on the channel just sampled.
          if (stop_q || bus.stop || (!mode_q && is_top(mask_q, ch_q))) begin
            drn_d   = '0;
            state_d = DRAIN;
          end else begin
            ch_d = next_ch(mask_q, ch_q);
          end
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      DRAIN: begin
        if (drn_q == DRN_W'(LAT - 1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          drn_d = drn_q + DRN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      mode_q  <= 1'b0;
      dwell_q <= '0;
      cnt_q   <= '0;
      ch_q    <= '0;
      stop_q  <= 1'b0;
      drn_q   <= '0;
      done_q  <= 1'b0;
      dly_q   <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      dwell_q  <= dwell_d;
      cnt_q    <= cnt_d;
      ch_q     <= ch_d;
      stop_q   <= stop_d;
      drn_q    <= drn_d;
      done_q   <= done_d;
      // Tag pipeline mirrors the mux latency.
      dly_q[0] <= {tag_vld, ch_q};
      for (int i = 1; i < LAT; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  assign bus.s0         = ch_q[1];
  assign bus.s1         = ch_q[0];
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.sample_vld = dly_q[LAT-1][2];
  assign bus.sample_ch  = dly_q[LAT-1][1:0];

endmodule
